// File: rtl/reg_wr_if.sv
// Register-bus write port plus downstream write-request channel of reg_wr_queue.
// Downstream handshake: m_valid/m_addr/m_data hold steady until the edge where
// m_valid and m_ready are both high; that edge transfers exactly one entry, and
// m_valid never depends on m_ready.
interface reg_wr_if;
  logic        write;
  logic [7:0]  address;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_addr;
  logic [15:0] m_data;
  logic        full;
  logic        empty;

  // Queue side.
  modport slave (
    input  write, address, data_in, m_ready,
    output data_out, m_valid, m_addr, m_data, full, empty
  );

  // Bus master / downstream consumer side.
  modport master (
    output write, address, data_in, m_ready,
    input  data_out, m_valid, m_addr, m_data, full, empty
  );
endinterface

// File: rtl/reg_wr_queue.sv
// Queues register-bus writes and replays them in order on a downstream
// valid/ready channel. Address 8'hFF is a control register: writing bit 0 high
// clears the sticky overflow flag. Status is readable on data_out.
module reg_wr_queue #(
  parameter int DEPTH = 8
) (
  input  logic      clk,
  input  logic      rst,
  reg_wr_if.slave   bus
);

  localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0] DEPTH_C = 5'(DEPTH);
  localparam logic [7:0] CTRL_ADDR = 8'hFF;

  logic [23:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW-1:0] wr_ptr_next, rd_ptr_next;
  logic [4:0]    count, count_next;
  logic          overflow, overflow_next;
  logic [23:0]   head_q, head_next;
  logic [15:0]   status_q, status_next;

  logic          full_i, empty_i;
  logic          pop, push_req, push_ok, drop, ctrl_clr;

  assign full_i  = (count == DEPTH_C);
  assign empty_i = (count == 5'd0);

  assign bus.full     = full_i;
  assign bus.empty    = empty_i;
  assign bus.m_valid  = !empty_i;
  assign bus.m_addr   = head_q[23:16];
  assign bus.m_data   = head_q[15:0];
  assign bus.data_out = status_q;

  // Decode this edge's push/pop/control events and the resulting next state.
  always_comb begin
    pop           = !empty_i && bus.m_ready;
    push_req      = bus.write && (bus.address != CTRL_ADDR);
    ctrl_clr      = bus.write && (bus.address == CTRL_ADDR) && bus.data_in[0];
    // A full queue still takes a push when the head leaves on the same edge.
    push_ok       = push_req && (!full_i || pop);
    drop          = push_req && full_i && !pop;

    wr_ptr_next   = push_ok ? wr_ptr + 1'b1 : wr_ptr;
    rd_ptr_next   = pop ? rd_ptr + 1'b1 : rd_ptr;

    count_next    = count;
    case ({push_ok, pop})
      2'b10:   count_next = count + 5'd1;
      2'b01:   count_next = count - 5'd1;
      default: count_next = count;
    endcase

    // A drop on the same edge as a clear leaves the flag set.
    overflow_next = overflow;
    if (ctrl_clr) overflow_next = 1'b0;
    if (drop)     overflow_next = 1'b1;

    // Next head: the entry being written this edge if it lands in the head
    // slot (queue empty, or last entry popping), otherwise from storage.
    head_next = head_q;
    if (count_next != 5'd0) begin
      if (push_ok && (rd_ptr_next == wr_ptr))
        head_next = {bus.address, bus.data_in};
      else
        head_next = mem[rd_ptr_next];
    end

    status_next = {overflow_next,
                   (count_next == DEPTH_C),
                   (count_next == 5'd0),
                   8'h00,
                   count_next};
  end

  // Entry storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= {bus.address, bus.data_in};
  end

  // Pointers, occupancy, flags, head and status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= 5'd0;
      overflow <= 1'b0;
      head_q   <= 24'h0;
      status_q <= 16'h2000;
    end else begin
      wr_ptr   <= wr_ptr_next;
      rd_ptr   <= rd_ptr_next;
      count    <= count_next;
      overflow <= overflow_next;
      head_q   <= head_next;
      status_q <= status_next;
    end
  end

endmodule

// File: tb/tb_reg_wr_queue.sv
// Directed plus randomized checking of reg_wr_queue (DEPTH=8) against a
// queue-based reference model.
module tb_reg_wr_queue;
  localparam int DEPTH = 8;

  logic clk;
  logic rst;
  reg_wr_if bus ();

  reg_wr_queue #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: queue of {addr,data} plus sticky overflow flag.
  logic [23:0] exp_q[$];
  logic        exp_ovf;
  int          n_assert;
  int          n_fail;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [15:0] exp_status();
    logic [4:0] c;
    c = 5'(exp_q.size());
    return {exp_ovf, (exp_q.size() == DEPTH), (exp_q.size() == 0), 8'h00, c};
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".m_valid"},  32'(bus.m_valid),  32'(exp_q.size() != 0));
    chk({tag, ".full"},     32'(bus.full),     32'(exp_q.size() == DEPTH));
    chk({tag, ".empty"},    32'(bus.empty),    32'(exp_q.size() == 0));
    chk({tag, ".data_out"}, 32'(bus.data_out), 32'(exp_status()));
    if (exp_q.size() != 0) begin
      chk({tag, ".m_addr"}, 32'(bus.m_addr), 32'(exp_q[0][23:16]));
      chk({tag, ".m_data"}, 32'(bus.m_data), 32'(exp_q[0][15:0]));
    end
  endtask

  // Driver: called at a negedge; applies one bus cycle, updates the model at
  // the posedge, then checks outputs at the following negedge.
  task automatic cycle(input logic w, input logic [7:0] a, input logic [15:0] d,
                       input logic r, input string tag);
    logic pop, push, full_pre;
    bus.write   = w;
    bus.address = a;
    bus.data_in = d;
    bus.m_ready = r;
    @(posedge clk);
    pop      = r && (exp_q.size() != 0);
    push     = w && (a != 8'hFF);
    full_pre = (exp_q.size() == DEPTH);
    if (pop) void'(exp_q.pop_front());
    if (w && (a == 8'hFF) && d[0]) exp_ovf = 1'b0;
    if (push) begin
      if (full_pre && !pop) exp_ovf = 1'b1;
      else exp_q.push_back({a, d});
    end
    @(negedge clk);
    bus.write = 1'b0;
    check_all(tag);
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_ovf = 1'b0;
  endtask

  initial begin
    n_assert    = 0;
    n_fail      = 0;
    bus.write   = 1'b0;
    bus.address = 8'h00;
    bus.data_in = 16'h0000;
    bus.m_ready = 1'b0;
    model_reset();

    // Reset state.
    rst = 1'b1;
    #3;
    chk("reset.data_out", 32'(bus.data_out), 32'h2000);
    chk("reset.m_valid",  32'(bus.m_valid),  32'h0);
    chk("reset.full",     32'(bus.full),     32'h0);
    chk("reset.empty",    32'(bus.empty),    32'h1);
    chk("reset.m_addr",   32'(bus.m_addr),   32'h0);
    chk("reset.m_data",   32'(bus.m_data),   32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Single push, visible next cycle, no bypass.
    cycle(1'b1, 8'h10, 16'hA5A5, 1'b0, "push1");
    chk("push1.status", 32'(bus.data_out), 32'h0001);
    chk("push1.addr",   32'(bus.m_addr),   32'h10);
    chk("push1.data",   32'(bus.m_data),   32'hA5A5);
    cycle(1'b0, 8'h00, 16'h0000, 1'b0, "stall");
    cycle(1'b0, 8'h00, 16'h0000, 1'b1, "pop1");

    // Push into empty with m_ready high must not bypass.
    cycle(1'b1, 8'h22, 16'h1234, 1'b1, "nobypass");
    cycle(1'b0, 8'h00, 16'h0000, 1'b1, "nobypass_pop");

    // Fill to full, then overflow.
    for (int i = 0; i < DEPTH; i++)
      cycle(1'b1, 8'(i + 1), 16'($urandom), 1'b0, "fill");
    chk("fill.status", 32'(bus.data_out), 32'h4008);
    cycle(1'b1, 8'h77, 16'hDEAD, 1'b0, "ovf_push");
    chk("ovf.status", 32'(bus.data_out), 32'hC008);

    // Control writes: bit0=0 no effect, bit0=1 clears overflow.
    cycle(1'b1, 8'hFF, 16'hFFFE, 1'b0, "ctrl_noclr");
    chk("ctrl_noclr.status", 32'(bus.data_out), 32'hC008);
    cycle(1'b1, 8'hFF, 16'h0001, 1'b0, "ctrl_clr");
    chk("ctrl_clr.status", 32'(bus.data_out), 32'h4008);

    // Push while full with a same-edge pop is accepted.
    cycle(1'b1, 8'h99, 16'hBEEF, 1'b1, "full_pushpop");
    chk("full_pushpop.status", 32'(bus.data_out), 32'h4008);

    // Drain in order (head checked every cycle).
    for (int i = 0; i < DEPTH; i++)
      cycle(1'b0, 8'h00, 16'h0000, 1'b1, "drain");
    chk("drain.status", 32'(bus.data_out), 32'h2000);

    // Randomized traffic, with occasional control writes.
    for (int i = 0; i < 300; i++) begin
      logic [7:0] a;
      a = ($urandom_range(0, 9) == 0) ? 8'hFF : 8'($urandom_range(0, 254));
      cycle(1'($urandom_range(0, 2) != 0), a, 16'($urandom),
            1'($urandom_range(0, 1)), "rand");
    end
    for (int i = 0; i < DEPTH + 1; i++)
      cycle(1'b0, 8'h00, 16'h0000, 1'b1, "rand_drain");

    // Asynchronous reset with three entries queued, mid-handshake.
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 8'(8'h40 + i), 16'(16'h5000 + i), 1'b0, "pre_rst");
    bus.m_ready = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("midrst.m_valid",  32'(bus.m_valid),  32'h0);
    chk("midrst.data_out", 32'(bus.data_out), 32'h2000);
    chk("midrst.m_addr",   32'(bus.m_addr),   32'h0);
    @(negedge clk);
    check_all("in_rst");
    rst = 1'b0;

    // First edge after reset release accepts a push.
    cycle(1'b1, 8'h5A, 16'hC0DE, 1'b0, "post_rst");
    chk("post_rst.status", 32'(bus.data_out), 32'h0001);
    cycle(1'b0, 8'h00, 16'h0000, 1'b1, "post_rst_pop");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
